// File: rtl/bp_pkg.sv
// Shared BTB definitions: geometry, entry field offsets, counter encodings and update rule.
package bp_pkg;

    localparam int unsigned ENTRIES = 128;
    localparam int unsigned IDX_W   = 7;
    localparam int unsigned TAG_W   = 30 - IDX_W;
    localparam int unsigned ENTRY_W = 1 + TAG_W + 30 + 2;

    // Entry layout: {valid, tag, target[31:2], ctr}
    localparam int unsigned CTR_LSB   = 0;
    localparam int unsigned TGT_LSB   = 2;
    localparam int unsigned TAG_LSB   = 32;
    localparam int unsigned VALID_BIT = ENTRY_W - 1;

    localparam logic [1:0] CTR_ST  = 2'b00;
    localparam logic [1:0] CTR_WT  = 2'b01;
    localparam logic [1:0] CTR_WNT = 2'b10;
    localparam logic [1:0] CTR_SNT = 2'b11;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } bp_state_e;

    // Taken moves toward strongly-taken (00), not-taken toward strongly-not-taken (11).
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == CTR_ST) ? CTR_ST : ctr - 2'd1;
        end else begin
            res = (ctr == CTR_SNT) ? CTR_SNT : ctr + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Two-entry synchronous FIFO holding pending BTB writes as {index, entry}.
module btb_upd_fifo #(
    parameter int unsigned Width = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr) begin
            wptr_d = 1'b0;
            rptr_d = 1'b0;
            cnt_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata;
                wptr_d        = ~wptr_q;
            end
            if (do_pop) begin
                rptr_d = ~rptr_q;
            end
            cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/btb_port_ctrl.sv
// BTB RAM port controller: clear sweep, lookup/update arbitration and prediction stage.
module btb_port_ctrl
    import bp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_req,
    output logic               busy,
    input  logic               lookup_req,
    input  logic [31:0]        lookup_pc,
    output logic               if_stall,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    output logic [1:0]         pred_ctr,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [31:0]        upd_pc,
    input  logic [31:0]        upd_target,
    input  logic               upd_taken,
    input  logic               upd_hit,
    input  logic [1:0]         upd_ctr_old,
    output logic               mem_en,
    output logic               mem_we,
    output logic [IDX_W-1:0]   mem_addr,
    output logic [ENTRY_W-1:0] mem_wdata,
    input  logic [ENTRY_W-1:0] mem_rdata
);

    localparam int unsigned QW = ENTRY_W + IDX_W;

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             rd_pend_q, rd_pend_d;   // RAM read issued last cycle
    logic             clr_pend_q, clr_pend_d; // lookup answered without RAM during sweep
    logic [TAG_W-1:0] lk_tag_q, lk_tag_d;

    logic          q_push, q_pop, q_clr, q_full, q_empty;
    logic [QW-1:0] q_wdata, q_rdata;
    logic [1:0]    upd_ctr;
    logic          mem_en_c, mem_we_c;
    logic          hit;
    logic          unused_lsbs;

    assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign upd_ctr = upd_hit ? ctr_next(upd_ctr_old, upd_taken) : CTR_ST;
    assign q_wdata = {upd_pc[IDX_W+1:2], 1'b1, upd_pc[31:IDX_W+2], upd_target[31:2], upd_ctr};
    // Miss-and-not-taken carries no information worth installing.
    assign q_push  = upd_valid && upd_ready && (upd_hit || upd_taken);

    btb_upd_fifo #(
        .Width(QW)
    ) u_upd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (q_clr),
        .push  (q_push),
        .pop   (q_pop),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        rd_pend_d  = 1'b0;
        clr_pend_d = 1'b0;
        lk_tag_d   = lk_tag_q;
        mem_en_c   = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_stall   = 1'b0;
        q_pop      = 1'b0;
        q_clr      = 1'b0;
        busy       = 1'b0;
        upd_ready  = 1'b0;
        unique case (state_q)
            StClear: begin
                busy       = 1'b1;
                mem_en_c   = 1'b1;
                mem_we_c   = 1'b1;
                mem_addr   = clr_idx_q;
                clr_pend_d = lookup_req;
                clr_idx_d  = clr_idx_q + 1'b1;
                if (flush_req) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                upd_ready = !q_full;
                if (q_full) begin
                    mem_en_c  = 1'b1;
                    mem_we_c  = 1'b1;
                    mem_addr  = q_rdata[ENTRY_W +: IDX_W];
                    mem_wdata = q_rdata[ENTRY_W-1:0];
                    q_pop     = 1'b1;
                    if_stall  = lookup_req;
                end else if (lookup_req) begin
                    mem_en_c  = 1'b1;
                    mem_addr  = lookup_pc[IDX_W+1:2];
                    rd_pend_d = 1'b1;
                    lk_tag_d  = lookup_pc[31:IDX_W+2];
                end else if (!q_empty) begin
                    mem_en_c  = 1'b1;
                    mem_we_c  = 1'b1;
                    mem_addr  = q_rdata[ENTRY_W +: IDX_W];
                    mem_wdata = q_rdata[ENTRY_W-1:0];
                    q_pop     = 1'b1;
                end
                // The write granted this cycle still lands; only queued updates are dropped.
                if (flush_req) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                    q_clr     = 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    assign mem_en = mem_en_c && rst_n;
    assign mem_we = mem_we_c && rst_n;

    assign hit         = rd_pend_q && mem_rdata[VALID_BIT]
                         && (mem_rdata[TAG_LSB +: TAG_W] == lk_tag_q);
    assign pred_valid  = rd_pend_q || clr_pend_q;
    assign pred_taken  = hit && !mem_rdata[CTR_LSB + 1];
    assign pred_target = rd_pend_q ? {mem_rdata[TGT_LSB +: 30], 2'b00} : 32'd0;
    assign pred_ctr    = rd_pend_q ? mem_rdata[CTR_LSB +: 2] : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StClear;
            clr_idx_q  <= '0;
            rd_pend_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            lk_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rd_pend_q  <= rd_pend_d;
            clr_pend_q <= clr_pend_d;
            lk_tag_q   <= lk_tag_d;
        end
    end

endmodule

// File: tb/tb_btb_port_ctrl.sv
// Directed bench for btb_port_ctrl with a RAM model and prediction/write scoreboards.
module tb_btb_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush_req;
    logic        busy;
    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic        if_stall;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_ctr;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_hit;
    logic [1:0]  upd_ctr_old;
    logic        mem_en;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [55:0] mem_wdata;
    logic [55:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        taken;
        logic [31:0] tgt;
        logic [1:0]  ctr;
        logic        full;
    } pred_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [55:0] data;
    } wr_t;

    pred_t pq[$];
    wr_t   wq[$];
    logic [55:0] ram [128];

    btb_port_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req   (flush_req),
        .busy        (busy),
        .lookup_req  (lookup_req),
        .lookup_pc   (lookup_pc),
        .if_stall    (if_stall),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_ctr    (pred_ctr),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_hit     (upd_hit),
        .upd_ctr_old (upd_ctr_old),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [55:0] mk_entry(input logic [31:0] pc, input logic [31:0] tgt,
                                             input logic [1:0] ctr);
        return {1'b1, pc[31:9], tgt[31:2], ctr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected predictions and update writes whenever the DUT presents them.
    always @(negedge clk) begin
        pred_t p;
        wr_t   w;
        if (rst_n && pred_valid) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pred_unexpected: got taken=%b tgt=%h", pred_taken, pred_target);
            end else begin
                p = pq.pop_front();
                if (pred_taken !== p.taken ||
                    (p.full && (pred_target !== p.tgt || pred_ctr !== p.ctr))) begin
                    errors++;
                    $display("FAIL pred: got taken=%b tgt=%h ctr=%b expected taken=%b tgt=%h ctr=%b",
                             pred_taken, pred_target, pred_ctr, p.taken, p.tgt, p.ctr);
                end
            end
        end
        if (rst_n && mem_we && !busy) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                w = wq.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_wdata, w.addr, w.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                       input logic hit, input logic [1:0] old, input bit exp_wr,
                       input logic [1:0] exp_ctr);
        int k;
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
        upd_taken = taken; upd_hit = hit; upd_ctr_old = old;
        k = 0;
        @(negedge clk);
        while (!upd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("upd_ready_wait", {63'd0, upd_ready}, 64'd1);
        if (exp_wr) wq.push_back('{pc[8:2], mk_entry(pc, tgt, exp_ctr)});
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic [1:0] ctr);
        int k;
        lookup_req = 1'b1; lookup_pc = pc;
        k = 0;
        @(negedge clk);
        while (if_stall && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("lookup_grant_wait", {63'd0, if_stall}, 64'd0);
        pq.push_back('{taken, tgt, ctr, 1'b1});
        @(posedge clk);
        #1;
        lookup_req = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush_req = 1'b0; lookup_req = 1'b0; lookup_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        upd_hit = 1'b0; upd_ctr_old = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_pred_valid", {63'd0, pred_valid}, 64'd0);
        chk("rst_upd_ready", {63'd0, upd_ready}, 64'd0);
        chk("rst_if_stall", {63'd0, if_stall}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clear sweep; one lookup mid-sweep must answer not-taken without touching the RAM.
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk("sweep_busy", {63'd0, busy}, 64'd1);
            chk("sweep_we", {63'd0, mem_we}, 64'd1);
            chk("sweep_addr", {57'd0, mem_addr}, 64'(i));
            chk("sweep_wdata", {8'd0, mem_wdata}, 64'd0);
            chk("sweep_upd_ready", {63'd0, upd_ready}, 64'd0);
            @(posedge clk);
            #1;
            lookup_req = (i == 9);
            lookup_pc  = 32'h40;
            if (i == 9) pq.push_back('{1'b0, 32'd0, 2'b00, 1'b0});
        end
        @(negedge clk);
        chk("run_busy", {63'd0, busy}, 64'd0);
        chk("run_upd_ready", {63'd0, upd_ready}, 64'd1);
        chk("run_idle_mem_en", {63'd0, mem_en}, 64'd0);
        @(posedge clk);
        #1;

        // Install by taken miss, then walk the counter with not-taken hits.
        upd(32'h40, 32'h100, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00);
        idle(3);
        lookup(32'h40, 1'b1, 32'h100, 2'b00);
        idle(2);
        upd(32'h40, 32'h100, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01);
        upd(32'h40, 32'h100, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10);
        upd(32'h40, 32'h100, 1'b0, 1'b1, 2'b10, 1'b1, 2'b11);
        upd(32'h40, 32'h100, 1'b0, 1'b1, 2'b11, 1'b1, 2'b11);
        idle(3);
        lookup(32'h40, 1'b0, 32'h100, 2'b11);
        idle(2);
        upd(32'h40, 32'h100, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10);
        idle(3);
        lookup(32'h40, 1'b0, 32'h100, 2'b10);
        idle(2);

        // Same index, different tag: no hit; a miss-not-taken update must not write.
        lookup(32'h240, 1'b0, 32'h100, 2'b10);
        upd(32'h240, 32'h500, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        idle(4);
        lookup(32'h40, 1'b0, 32'h100, 2'b10);
        idle(2);

        // Held lookup with two queued updates: full queue steals the port for one cycle.
        lookup_req = 1'b1; lookup_pc = 32'h80;
        upd_valid = 1'b1; upd_pc = 32'h1000; upd_target = 32'h2000;
        upd_taken = 1'b1; upd_hit = 1'b0; upd_ctr_old = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 2) begin
                chk("fill_upd_ready", {63'd0, upd_ready}, 64'd1);
                wq.push_back('{upd_pc[8:2], mk_entry(upd_pc, upd_target, 2'b00)});
            end
            if (c == 2) begin
                chk("full_if_stall", {63'd0, if_stall}, 64'd1);
                chk("full_upd_ready", {63'd0, upd_ready}, 64'd0);
                chk("full_mem_we", {63'd0, mem_we}, 64'd1);
            end else begin
                chk("held_if_stall", {63'd0, if_stall}, 64'd0);
                pq.push_back('{1'b0, 32'd0, 2'b00, 1'b1});
            end
            if (c == 3) chk("recover_upd_ready", {63'd0, upd_ready}, 64'd1);
            @(posedge clk);
            #1;
            if (c == 0) begin
                upd_pc = 32'h1004; upd_target = 32'h3000;
            end
            if (c == 1) upd_valid = 1'b0;
        end
        lookup_req = 1'b0;
        idle(4);

        // Flush with an update queued behind a lookup: the queued update is dropped.
        lookup_req = 1'b1; lookup_pc = 32'h80;
        upd_valid = 1'b1; upd_pc = 32'h2000; upd_target = 32'h4000;
        upd_taken = 1'b1; upd_hit = 1'b0;
        @(negedge clk);
        chk("flush_pre_upd_ready", {63'd0, upd_ready}, 64'd1);
        pq.push_back('{1'b0, 32'd0, 2'b00, 1'b1});
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        chk("flush_if_stall", {63'd0, if_stall}, 64'd0);
        pq.push_back('{1'b0, 32'd0, 2'b00, 1'b1});
        @(posedge clk);
        #1;
        flush_req  = 1'b0;
        lookup_req = 1'b0;
        n = 0;
        @(negedge clk);
        chk("flush_upd_ready", {63'd0, upd_ready}, 64'd0);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("flush_sweep_len", 64'(n), 64'd128);
        @(posedge clk);
        #1;
        lookup(32'h40, 1'b0, 32'd0, 2'b00);
        lookup(32'h2000, 1'b0, 32'd0, 2'b00);
        idle(5);

        chk("pred_queue_drained", 64'(pq.size()), 64'd0);
        chk("write_queue_drained", 64'(wq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
